fpu_md_ctrl: RTL

- Sequencing controller for the double-precision multiply/divide path of the FPU.
- Accepts one mul/div operation per handshake along with its 4-bit operand class flags.
- Routes special operands straight to the special-case result generator. Otherwise starts the multiplier (fixed latency) or the iterative divider (counted iterations), and holds the result valid until the consumer takes it.
- Also produces the IEEE invalid-operation and divide-by-zero exception bits for the operation.

---
 rtl/fpu_md_pkg.sv | 30 +++
 rtl/md_iter_cnt.sv | 31 +++
 rtl/fpu_md_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fpu_md_pkg.sv
// Shared definitions for the FP multiply/divide sequencing controller:
// operand class flag indices, FSM states and the exception decode.
package fpu_md_pkg;

  localparam int FL_ZERO = 0;
  localparam int FL_INF  = 1;
  localparam int FL_QNAN = 2;
  localparam int FL_SNAN = 3;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_SPEC = 3'd1,
    MD_MUL  = 3'd2,
    MD_DIV  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // Returns {nv, dz} for an operation given both operand class flags.
  function automatic logic [1:0] md_exc(input logic [3:0] fla, input logic [3:0] flb,
                                        input logic fdiv);
    logic nv, dz;
    nv = fla[FL_SNAN] | flb[FL_SNAN]
       | (!fdiv & ((fla[FL_ZERO] & flb[FL_INF]) | (fla[FL_INF] & flb[FL_ZERO])))
       | (fdiv & fla[FL_ZERO] & flb[FL_ZERO])
       | (fdiv & fla[FL_INF] & flb[FL_INF]);
    dz = fdiv & (fla == 4'b0000) & (flb == 4'b0001);
    return {nv, dz};
  endfunction

endpackage

// File: rtl/md_iter_cnt.sv
// Loadable up-counter with terminal-count flag, shared by the MUL latency
// wait and the DIV iteration sequence.
module md_iter_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == tc);

endmodule

// File: rtl/fpu_md_ctrl.sv
// Sequencing controller for the double-precision mul/div path: routes special
// operands to the special-case generator, otherwise times the mul or div datapath.
module fpu_md_ctrl
  import fpu_md_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_ITER = 27,
  parameter int CNT_W    = $clog2(DIV_ITER+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_fdiv,
  input  logic [3:0]       in_fla,
  input  logic [3:0]       in_flb,
  output logic [3:0]       op_fla,
  output logic [3:0]       op_flb,
  output logic             op_fdiv,
  output logic             dp_start,
  output logic             dp_iter_en,
  output logic [CNT_W-1:0] dp_iter_cnt,
  output logic             dp_last,
  output logic             res_sel_spec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             exc_nv,
  output logic             exc_dz,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MUL_TC = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(DIV_ITER - 1);

  md_state_e        state_q;
  logic [3:0]       fla_q, flb_q;
  logic             fdiv_q, nv_q, dz_q;
  logic             start_q, spec_q, ovld_q;
  logic             accept, special, counting, cnt_last, cnt_clr;
  logic [CNT_W-1:0] cnt, cnt_tc;

  assign in_ready = (state_q == MD_IDLE) && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign special  = (|in_fla) || (|in_flb);
  assign counting = (state_q == MD_MUL) || (state_q == MD_DIV);
  assign cnt_tc   = (state_q == MD_DIV) ? DIV_TC : MUL_TC;
  // Clearing at terminal count keeps the counter at 0 outside MUL/DIV.
  assign cnt_clr  = flush || accept || (counting && cnt_last);

  md_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (counting),
    .tc   (cnt_tc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      fla_q   <= '0;
      flb_q   <= '0;
      fdiv_q  <= 1'b0;
      nv_q    <= 1'b0;
      dz_q    <= 1'b0;
      start_q <= 1'b0;
      spec_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else if (flush) begin
      // Operand and exception registers are left as-is; nothing qualifies them.
      state_q <= MD_IDLE;
      start_q <= 1'b0;
      spec_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: if (accept) begin
          state_q          <= special ? MD_SPEC : (in_fdiv ? MD_DIV : MD_MUL);
          fla_q            <= in_fla;
          flb_q            <= in_flb;
          fdiv_q           <= in_fdiv;
          {nv_q, dz_q}     <= md_exc(in_fla, in_flb, in_fdiv);
          spec_q           <= special;
          start_q          <= !special;
        end
        MD_SPEC: begin
          state_q <= MD_DONE;
          ovld_q  <= 1'b1;
        end
        MD_MUL, MD_DIV: if (cnt_last) begin
          state_q <= MD_DONE;
          ovld_q  <= 1'b1;
        end
        MD_DONE: if (out_ready) begin
          state_q <= MD_IDLE;
          ovld_q  <= 1'b0;
          spec_q  <= 1'b0;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign op_fla       = fla_q;
  assign op_flb       = flb_q;
  assign op_fdiv      = fdiv_q;
  assign dp_start     = start_q;
  assign dp_iter_en   = (state_q == MD_DIV);
  assign dp_iter_cnt  = cnt;
  assign dp_last      = (state_q == MD_DIV) && cnt_last;
  assign res_sel_spec = spec_q;
  assign out_valid    = ovld_q;
  assign exc_nv       = nv_q;
  assign exc_dz       = dz_q;
  assign busy         = (state_q != MD_IDLE);

endmodule
